// File: rtl/keypad_scan_hex_if.sv
// Key delivery bundle for keypad_scan_hex.
//   keyHex     : hex code of the accepted key (stable while keyValid=1)
//   keyValid   : keyHex holds an unconsumed key
//   keyReady   : consumer takes keyHex on a clock edge where keyValid=1
//   keyHeld    : a debounced key is currently held down
//   keyOverrun : one-cycle pulse when a new press is dropped
// master = keypad scanner side, slave = consumer side.
interface keypad_scan_hex_if;
  logic [3:0] keyHex;
  logic       keyValid;
  logic       keyReady;
  logic       keyHeld;
  logic       keyOverrun;

  modport master (output keyHex, output keyValid, output keyHeld,
                  output keyOverrun, input keyReady);
  modport slave  (input keyHex, input keyValid, input keyHeld,
                  input keyOverrun, output keyReady);
endinterface

// File: rtl/keypad_scan_hex.sv
// 4x4 matrix keypad scanner with frame-based debounce and valid/ready output.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   rowN    : keypad rows, active low, asynchronous to clock
//   colN    : keypad column drive, active low, one column at a time
//   key     : key delivery bundle (keyHex/keyValid/keyReady/keyHeld/keyOverrun)
module keypad_scan_hex #(
  parameter int unsigned f              = 100000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [3:0]                rowN,
  output logic [3:0]                colN,
  keypad_scan_hex_if.master         key
);

  localparam int unsigned COL_TICKS = f / SCAN_HZ;
  localparam int unsigned TW        = $clog2(COL_TICKS);
  localparam int unsigned CW        = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(COL_TICKS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_PRESSED, ST_RELEASE} state_e;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [TW-1:0] dwell_q;
  logic [1:0]    col_q;
  logic [11:0]   frame_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    hex_q;
  logic          valid_q, overrun_q;

  logic          tick, frame_done, accept;
  logic [15:0]   frame_now;
  logic [4:0]    hit_cnt;
  logic [3:0]    hit_idx, key_k;
  logic          is_none, is_single;

  function automatic logic [3:0] hex_of(input logic [3:0] idx);
    // idx = col*4 + row
    case (idx)
      4'd0:  hex_of = 4'h1;  4'd1:  hex_of = 4'h4;
      4'd2:  hex_of = 4'h7;  4'd3:  hex_of = 4'h0;
      4'd4:  hex_of = 4'h2;  4'd5:  hex_of = 4'h5;
      4'd6:  hex_of = 4'h8;  4'd7:  hex_of = 4'hF;
      4'd8:  hex_of = 4'h3;  4'd9:  hex_of = 4'h6;
      4'd10: hex_of = 4'h9;  4'd11: hex_of = 4'hE;
      4'd12: hex_of = 4'hA;  4'd13: hex_of = 4'hB;
      4'd14: hex_of = 4'hC;  default: hex_of = 4'hD;
    endcase
  endfunction

  assign tick       = (dwell_q == TICK_LAST);
  assign frame_done = tick && (col_q == 2'd3);
  assign colN       = ~(4'b0001 << col_q);

  // Column 3 is never stored: the frame is judged on the clock it is captured.
  assign frame_now  = {~row_sync_q, frame_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      dwell_q    <= '0;
      col_q      <= '0;
      frame_q    <= '0;
    end else begin
      row_meta_q <= rowN;
      row_sync_q <= row_meta_q;
      dwell_q    <= tick ? '0 : dwell_q + TW'(1);
      if (tick) begin
        col_q <= col_q + 2'd1;
        case (col_q)
          2'd0:    frame_q[3:0]  <= ~row_sync_q;
          2'd1:    frame_q[7:4]  <= ~row_sync_q;
          2'd2:    frame_q[11:8] <= ~row_sync_q;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (frame_now[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = i[3:0];
      end
    end
  end

  assign is_none   = (hit_cnt == 5'd0);
  assign is_single = (hit_cnt == 5'd1);
  assign key_k     = hex_of(hit_idx);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (is_single) begin
            cand_d = key_k;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = ST_PRESSED;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (is_single && key_k == cand_q) begin
            if (cnt_q + CW'(1) == CNT_FULL) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = ST_PRESSED;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (is_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_RELEASE;
            end
          end
        end
        default: begin
          if (is_none) begin
            if (cnt_q + CW'(1) == CNT_FULL) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_PRESSED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Accept always carries key_k: it only fires on SINGLE(cand).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hex_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (accept) begin
        if (!valid_q) begin
          hex_q   <= key_k;
          valid_q <= 1'b1;
        end else if (key.keyReady) begin
          hex_q <= key_k;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && key.keyReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign key.keyHex     = hex_q;
  assign key.keyValid   = valid_q;
  assign key.keyOverrun = overrun_q;
  assign key.keyHeld    = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan_hex.sv
module tb_keypad_scan_hex;

  localparam int DB = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  rowN, colN;
  logic [15:0] keys;          // bit h set = key with hex code h is pressed

  keypad_scan_hex_if kif();

  keypad_scan_hex #(.f(400), .SCAN_HZ(100), .DEBOUNCE_SCANS(DB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rowN    (rowN),
    .colN    (colN),
    .key     (kif)
  );

  always #5 clock = ~clock;

  // Physical keypad layout: hex code at column c, row r.
  logic [3:0] layout [16];
  initial begin
    layout = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
               4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
  end

  always_comb begin
    rowN = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!colN[c] && keys[layout[c*4+r]]) rowN[r] = 1'b0;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         cyc;
  bit         m_held;
  int         m_run, m_rel;
  logic [3:0] m_cand;
  bit         m_valid, m_ovr;
  logic [3:0] m_hex;
  bit         rand_rdy;
  int         pulses, ovr_cnt;
  bit         prev_valid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_run = 0; m_rel = 0; m_cand = '0;
    m_valid = 0; m_ovr = 0; m_hex = '0; cyc = 0; prev_valid = 0;
  endtask

  // One completed frame: count identical single-key frames while released,
  // count empty frames while held.
  task automatic frame_model(output bit acc, output logic [3:0] ahex);
    int n;
    logic [3:0] k;
    acc = 0; ahex = '0;
    n = $countones(keys);
    k = '0;
    for (int h = 0; h < 16; h++) if (keys[h]) k = 4'(h);
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && k != m_cand) m_run = 0;
        else begin
          if (m_run == 0) m_cand = k;
          m_run++;
          if (m_run == DB) begin
            acc = 1; ahex = k; m_held = 1; m_run = 0; m_rel = 0;
          end
        end
      end else m_run = 0;
    end else begin
      if (n == 0) begin
        m_rel++;
        if (m_rel == DB) begin m_held = 0; m_rel = 0; end
      end else m_rel = 0;
    end
  endtask

  task automatic step();
    bit rdy, acc;
    logic [3:0] ahex, one, ecol;
    @(posedge clock);
    rdy = kif.keyReady;
    cyc++;
    acc = 0; ahex = '0;
    if (cyc % 16 == 0) frame_model(acc, ahex);
    m_ovr = 0;
    if (acc) begin
      if (!m_valid) begin m_hex = ahex; m_valid = 1; end
      else if (rdy) m_hex = ahex;
      else m_ovr = 1;
    end else if (m_valid && rdy) m_valid = 0;
    #1;
    one  = 4'b0001;
    ecol = ~(one << ((cyc / 4) % 4));
    chk("colN", 16'(colN), 16'(ecol));
    chk("keyValid", 16'(kif.keyValid), 16'(m_valid));
    chk("keyHex", 16'(kif.keyHex), 16'(m_hex));
    chk("keyHeld", 16'(kif.keyHeld), 16'(m_held));
    chk("keyOverrun", 16'(kif.keyOverrun), 16'(m_ovr));
    if (kif.keyValid && !prev_valid) pulses++;
    prev_valid = kif.keyValid;
    if (kif.keyOverrun) ovr_cnt++;
    if (rand_rdy) kif.keyReady = 1'($urandom_range(0, 1));
  endtask

  task automatic frames(input logic [15:0] k, input int n);
    keys = k;
    for (int i = 0; i < n * 16; i++) step();
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_colN"}, 16'(colN), 16'h000E);
    chk({tag, "_valid"}, 16'(kif.keyValid), 16'h0);
    chk({tag, "_hex"}, 16'(kif.keyHex), 16'h0);
    chk({tag, "_held"}, 16'(kif.keyHeld), 16'h0);
    chk({tag, "_ovr"}, 16'(kif.keyOverrun), 16'h0);
    model_reset();
    keys = '0;
    @(negedge clock) reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rk;
    reset_n = 1'b0; keys = '0; kif.keyReady = 1'b1; rand_rdy = 0;
    pulses = 0; ovr_cnt = 0;
    model_reset();
    #3;
    do_reset("rst0");

    // Idle scan: 64 clocks
    frames('0, 4);

    // Key 5 held 6 frames, then released
    pulses = 0;
    frames(16'h0020, 6);
    frames('0, 4);
    chk("k5_pulses", 16'(pulses), 16'd1);
    chk("k5_hex", 16'(kif.keyHex), 16'h5);

    // Key 9 bouncing, then a clean hold
    pulses = 0;
    frames(16'h0200, 2);
    frames('0, 1);
    frames(16'h0200, 2);
    frames('0, 1);
    chk("k9_bounce", 16'(pulses), 16'd0);
    frames(16'h0200, 3);
    frames('0, 4);
    chk("k9_clean", 16'(pulses), 16'd1);
    chk("k9_hex", 16'(kif.keyHex), 16'h9);

    // Overrun: consumer stalled
    kif.keyReady = 1'b0; ovr_cnt = 0;
    frames(16'h0008, 4);
    frames('0, 4);
    frames(16'h0400, 4);
    chk("ovr_hex", 16'(kif.keyHex), 16'h3);
    chk("ovr_pulses", 16'(ovr_cnt), 16'd1);
    kif.keyReady = 1'b1;
    step();
    chk("ovr_cleared", 16'(kif.keyValid), 16'h0);
    for (int i = 0; i < 15; i++) step();
    frames('0, 4);

    // Two keys together, then only key 1
    pulses = 0;
    frames(16'h0042, 5);
    chk("multi_none", 16'(pulses), 16'd0);
    frames(16'h0002, 4);
    chk("multi_then1", 16'(pulses), 16'd1);
    chk("multi_hex", 16'(kif.keyHex), 16'h1);
    frames('0, 4);

    // Reset mid-CONFIRM
    keys = 16'h0080;
    for (int i = 0; i < 40; i++) step();
    do_reset("rst_confirm");
    // Reset while keyValid=1
    kif.keyReady = 1'b0;
    frames(16'h0080, 4);
    chk("pre_rst_valid", 16'(kif.keyValid), 16'h1);
    do_reset("rst_valid");
    kif.keyReady = 1'b1;
    frames('0, 2);

    // Randomized keypad activity with random consumer readiness
    rand_rdy = 1;
    for (int s = 0; s < 25; s++) begin
      case ($urandom_range(0, 3))
        0:       rk = '0;
        1, 2:    rk = 16'(1) << $urandom_range(0, 15);
        default: rk = (16'(1) << $urandom_range(0, 7)) | (16'(1) << $urandom_range(8, 15));
      endcase
      frames(rk, $urandom_range(1, 4));
    end
    rand_rdy = 0;
    frames('0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_hex.md
Name: keypad_scan_hex

Overview:
Input-side counterpart of the multiplexed seven-segment display driver. It drives a 4x4 matrix keypad one active-low column at a time and reads the active-low rows. It debounces presses over whole scan frames and delivers one 4-bit hex code per press through a valid/ready handshake. Typical use: feeding keypad digits into the same hex datapath that drives the display.

Parameters:
f, 100000000, system clock frequency in Hz
SCAN_HZ, 1000, column step rate in Hz; COL_TICKS = f/SCAN_HZ clocks per column dwell (must be >= 2)
DEBOUNCE_SCANS, 4, number of consecutive identical full frames needed to accept a press or a release (must be >= 1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
rowN  in  4  keypad rows, active low, asynchronous to clock
colN  out  4  keypad column drive, active low, one-hot-zero
keyHex  out  4  hex code of the accepted key
keyValid  out  1  keyHex holds an unconsumed key
keyReady  in  1  consumer accepts keyHex on a rising edge where keyValid=1
keyHeld  out  1  a debounced key is currently held down
keyOverrun  out  1  one-cycle pulse when a new press is dropped

Behaviour:
- Reset (async assert, sync release) sets: colIndex=0, colN=4'b1110, sync flops=4'hF, dwell and debounce counters=0, FSM=IDLE, keyHex=0, keyValid=0, keyHeld=0, keyOverrun=0. Reset mid-frame or mid-handshake discards everything, including any pending key.
- Synchronizer: rowN passes through 2 flops before any use.
- Column sequencer:
  - Dwell counter runs 0..COL_TICKS-1, width $clog2(COL_TICKS).
  - On the terminal count: capture the synchronized rows into frame bits [colIndex*4 +: 4] as pressed = ~rows, then advance colIndex 0->1->2->3->0.
  - colN = ~(4'b0001 << colIndex) at all times.
  - Capture after the terminal count of column 3 completes a frame. Frame length = 4*COL_TICKS clocks.
- Key map (col,row -> hex):
  - col0: rows 0..3 = 1,4,7,0
  - col1: 2,5,8,F
  - col2: 3,6,9,E
  - col3: A,B,C,D
- Frame classification: NONE (0 bits set), SINGLE(k) (exactly 1 bit set), MULTI (2 or more bits set).
- Debounce FSM, evaluated once per completed frame. Counter width is $clog2(DEBOUNCE_SCANS+1).
  - IDLE: SINGLE(k) -> cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately and go to PRESSED; otherwise go to CONFIRM. NONE or MULTI -> stay.
  - CONFIRM: SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED. Any other frame -> IDLE, cnt=0.
  - PRESSED: keyHeld=1. NONE -> RELEASE, cnt=1 (or straight to IDLE if DEBOUNCE_SCANS==1). SINGLE or MULTI -> stay; no repeat events, even if the key changes.
  - RELEASE: keyHeld stays 1. NONE -> cnt+1; when it reaches DEBOUNCE_SCANS -> IDLE, keyHeld=0. Any key -> PRESSED.
- Accept event, registered on the same clock as the FSM transition:
  - keyValid=0: keyHex<=cand, keyValid<=1.
  - keyValid=1 and keyReady=1 in the same cycle: keyHex<=cand, keyValid stays 1 (handoff and load together).
  - keyValid=1 and keyReady=0: new key dropped, keyOverrun=1 for one cycle, keyHex unchanged.
- Handshake:
  - keyValid=1 and keyReady=1 with no accept event -> keyValid<=0 next cycle.
  - keyHex is stable while keyValid=1.
  - keyReady is ignored while keyValid=0.
- Press latency: accept occurs on the final capture clock of the DEBOUNCE_SCANS-th consecutive SINGLE frame; keyValid rises one clock later.

Test Plan:
All tests use f=400, SCAN_HZ=100 (COL_TICKS=4, frame=16 clocks), DEBOUNCE_SCANS=3, and a bench keypad model that pulls row r low while colN drives the pressed key's column low.
- Reset then idle 64 clocks -> colN cycles 1110,1101,1011,0111 with 4 clocks each; keyValid=0; keyHeld=0.
- Hold key 5 (col1,row1) for 6 frames, keyReady=1 -> one keyValid pulse with keyHex=5, within 1 clock after frame 3 ends; keyHeld=1 until 3 NONE frames after release.
- Key 9 bouncing (present 2 frames, absent 1, present 2) -> no keyValid; a clean 3-frame hold then produces keyHex=9.
- keyReady=0: press 3 (debounced), release, then press A -> keyHex stays 3, keyOverrun pulses once; raising keyReady clears keyValid next clock.
- Keys 1 and 6 held together for 5 frames -> no event. Releasing 6 leaves SINGLE(1) -> keyHex=1 after 3 frames.
- Assert reset_n low mid-CONFIRM and again while keyValid=1 -> all outputs return immediately to reset values; colN=1110.
